// File: rtl/filter2d_pkg.sv
// ---------------------------------------------------------------------------
// filter2d_pkg
// Shared types and constants for the line-buffered 3x3 image filter.
//   state_t    : frame sequencer states
//   NTAP       : number of kernel taps (3x3)
//   IDENTITY_IDX : centre tap, set to 1 at reset so the filter copies
//   coef_t     : default-width signed coefficient
//   acc_width(): width of the 9-product sum that can never overflow
// ---------------------------------------------------------------------------
package filter2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam int NTAP         = 9;
    localparam int IDENTITY_IDX = 4;
    localparam int COEF_W       = 8;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Each product is (CW+DW+1) bits; nine of them need four more bits.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 5;
    endfunction

endpackage

// File: rtl/filter2d_lb_if.sv
// ---------------------------------------------------------------------------
// filter2d_lb_if
// Bundles the filter's frame handshake, kernel-load port and the
// single-port memory bus.
//   start/finish/busy/cfg_shift : frame control
//   h_write/h_idx/h_data        : coefficient load
//   cs/we/addr/din/dout         : memory bus (dout valid the cycle after a read)
// Modports:
//   master : the filter (drives the memory bus, reports finish/busy)
//   slave  : the host/memory side
// ---------------------------------------------------------------------------
interface filter2d_lb_if #(
    parameter int AW = 17,
    parameter int DW = 8,
    parameter int CW = 8
);

    logic          start;
    logic          finish;
    logic          busy;
    logic [3:0]    cfg_shift;
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          h_write;
    logic [3:0]    h_idx;
    logic [CW-1:0] h_data;

    modport master (
        input  start, cfg_shift, dout, h_write, h_idx, h_data,
        output finish, busy, cs, we, addr, din
    );

    modport slave (
        output start, cfg_shift, dout, h_write, h_idx, h_data,
        input  finish, busy, cs, we, addr, din
    );

endinterface

// File: rtl/filter2d_linebuf.sv
// ---------------------------------------------------------------------------
// filter2d_linebuf
// Two row buffers of IMG_W+1 pixels holding the previous two image rows.
// Reading is combinational at column col; on wen the middle row moves up
// into the top row and the new sample becomes the middle row, both at col.
// The extra column IMG_W holds the right-hand zero padding.
//   clk  : clock
//   clr  : synchronous clear of both rows (start of frame)
//   wen  : update both rows at col
//   col  : current column, 0..IMG_W
//   pix  : new sample for the middle row
//   top  : row y-2 at col
//   mid  : row y-1 at col
// ---------------------------------------------------------------------------
module filter2d_linebuf #(
    parameter int IMG_W = 256,
    parameter int DW    = 8,
    parameter int XW    = $clog2(IMG_W + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          wen,
    input  logic [XW-1:0] col,
    input  logic [DW-1:0] pix,
    output logic [DW-1:0] top,
    output logic [DW-1:0] mid
);

    logic [DW-1:0] row_top [IMG_W+1];
    logic [DW-1:0] row_mid [IMG_W+1];

    // NOTE: storage arrays carry no async reset; they are cleared
    // synchronously at every frame start, which is the only point where
    // their contents start to matter.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i <= IMG_W; i++) begin
                row_top[i] <= '0;
                row_mid[i] <= '0;
            end
        end else if (wen) begin
            row_top[col] <= row_mid[col];
            row_mid[col] <= pix;
        end
    end

    assign top = row_top[col];
    assign mid = row_mid[col];

endmodule

// File: rtl/filter2d_lb.sv
// ---------------------------------------------------------------------------
// filter2d_lb
// Line-buffered 3x3 filter. Reads an IMG_H x IMG_W image once in raster
// order from SRC_BASE, convolves it with a loadable signed kernel (zero
// padding at the borders), rounds, shifts, clamps and writes the result
// to DST_BASE of the same single-port memory.
//   clk     : clock
//   n_reset : asynchronous active-low reset
//   bus     : frame handshake, coefficient load and memory bus
// The scan walks virtual positions (y,x), y=0..IMG_H, x=0..IMG_W; the
// output for pixel (y-1,x-1) is written at position (y,x).
// ---------------------------------------------------------------------------
module filter2d_lb
    import filter2d_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int AW       = 17,
    parameter int DW       = 8,
    parameter int CW       = 8,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = IMG_W * IMG_H
) (
    input  logic          clk,
    input  logic          n_reset,
    filter2d_lb_if.master bus
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int PW = DW + CW + 1;
    localparam int SW = acc_width(DW, CW);

    localparam logic [XW-1:0]        X_LAST  = XW'(IMG_W);
    localparam logic [YW-1:0]        Y_LAST  = YW'(IMG_H);
    localparam logic signed [SW-1:0] PIX_MAX = SW'((1 << DW) - 1);

    state_t state, state_nxt;

    logic [XW-1:0]        x, x_nxt;
    logic [YW-1:0]        y, y_nxt;
    logic [3:0]           shift_q;
    logic signed [CW-1:0] h   [NTAP];
    logic [DW-1:0]        win [NTAP];

    logic          start_ok;
    logic          in_img;
    logic          has_out;
    logic          at_row_end;
    logic          frame_end;
    logic          nxt_in_img;
    logic          advance;
    logic [DW-1:0] cap_pix;
    logic [DW-1:0] lb_top;
    logic [DW-1:0] lb_mid;

    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] rounded;
    logic [DW-1:0]        result;
    logic [AW-1:0]        rd_addr;
    logic [AW-1:0]        wr_addr;

    // -----------------------------------------------------------------------
    // Position decode
    // -----------------------------------------------------------------------
    assign start_ok   = (state == IDLE) && bus.start;
    assign in_img     = (y < Y_LAST) && (x < X_LAST);
    assign has_out    = (y != '0) && (x != '0);
    assign at_row_end = (x == X_LAST);
    assign frame_end  = at_row_end && (y == Y_LAST);
    assign x_nxt      = at_row_end ? '0 : x + 1'b1;
    assign y_nxt      = at_row_end ? y + 1'b1 : y;
    assign nxt_in_img = (y_nxt < Y_LAST) && (x_nxt < X_LAST);

    // A position is finished after CAP when it has no output, else after WR.
    assign advance = ((state == CAP) && !has_out) || (state == WR);

    // Border positions contribute zero instead of whatever dout holds.
    assign cap_pix = in_img ? bus.dout : '0;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RD;
            RD:   state_nxt = CAP;
            CAP:  if (has_out) state_nxt = WR;
            WR:   state_nxt = state;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (advance) begin
            if (frame_end) begin
                state_nxt = DONE;
            end else begin
                state_nxt = nxt_in_img ? RD : CAP;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan counters and latched shift
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            x       <= '0;
            y       <= '0;
            shift_q <= '0;
        end else if (start_ok) begin
            x       <= '0;
            y       <= '0;
            shift_q <= bus.cfg_shift;
        end else if (advance && !frame_end) begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Coefficients: writable only while idle, identity after reset
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NTAP; i++) begin
                h[i] <= (i == IDENTITY_IDX) ? CW'(1) : '0;
            end
        end else if ((state == IDLE) && bus.h_write && (bus.h_idx <= 4'(NTAP - 1))) begin
            h[bus.h_idx] <= bus.h_data;
        end
    end

    // -----------------------------------------------------------------------
    // Line buffers and 3x3 window
    // -----------------------------------------------------------------------
    filter2d_linebuf #(
        .IMG_W (IMG_W),
        .DW    (DW),
        .XW    (XW)
    ) u_linebuf (
        .clk (clk),
        .clr (start_ok),
        .wen (state == CAP),
        .col (x),
        .pix (cap_pix),
        .top (lb_top),
        .mid (lb_mid)
    );

    // Window index r*3+c matches the kernel layout. Column 2 is the newest
    // (column x); at x=0 the older columns are the left zero padding.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NTAP; i++) begin
                win[i] <= '0;
            end
        end else if (state == CAP) begin
            for (int r = 0; r < 3; r++) begin
                win[r*3+0] <= (x == '0) ? '0 : win[r*3+1];
                win[r*3+1] <= (x == '0) ? '0 : win[r*3+2];
            end
            win[2] <= lb_top;
            win[5] <= lb_mid;
            win[8] <= cap_pix;
        end
    end

    // -----------------------------------------------------------------------
    // MAC, round-and-shift, clamp
    // -----------------------------------------------------------------------
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int i = 0; i < NTAP; i++) begin
            // Signed coefficient times zero-extended pixel.
            prod = PW'(h[i]) * PW'($signed({1'b0, win[i]}));
            acc  = acc + SW'(prod);
        end
    end

    always_comb begin
        rounded = acc;
        if (shift_q != 4'd0) begin
            rounded = (acc + (SW'(1) << (shift_q - 4'd1))) >>> shift_q;
        end
    end

    always_comb begin
        if (rounded[SW-1]) begin
            result = '0;
        end else if (rounded > PIX_MAX) begin
            result = '1;
        end else begin
            result = rounded[DW-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Memory bus, decoded from the registered state
    // -----------------------------------------------------------------------
    assign rd_addr = AW'(SRC_BASE) + AW'(y) * AW'(IMG_W) + AW'(x);
    assign wr_addr = AW'(DST_BASE) + (AW'(y) - AW'(1)) * AW'(IMG_W) + (AW'(x) - AW'(1));

    assign bus.busy   = (state != IDLE);
    assign bus.finish = (state == DONE);
    assign bus.cs     = (state == RD) || (state == WR);
    assign bus.we     = (state == WR);
    assign bus.addr   = (state == RD) ? rd_addr :
                        (state == WR) ? wr_addr : '0;
    assign bus.din    = (state == WR) ? result : '0;

endmodule

// File: tb/tb_filter2d_lb.sv
// ---------------------------------------------------------------------------
// tb_filter2d_lb
// Bench for filter2d_lb on a 4x4 image (SRC_BASE=0, DST_BASE=16).
// Expected writes (address, pixel) come from a direct zero-padded
// convolution model and are queued when a frame is started; each DUT
// write pops the queue and is compared.
// ---------------------------------------------------------------------------
module tb_filter2d_lb;
    import filter2d_pkg::*;

    localparam int W         = 4;
    localparam int H         = 4;
    localparam int NPIX      = W * H;
    localparam int DST       = NPIX;
    localparam int FRAME_CYC = 2 * NPIX + (H + 1) * (W + 1) + 1;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset;

    filter2d_lb_if #(.AW(8), .DW(8), .CW(8)) bus ();

    filter2d_lb #(
        .IMG_W    (W),
        .IMG_H    (H),
        .AW       (8),
        .DW       (8),
        .CW       (8),
        .SRC_BASE (0),
        .DST_BASE (DST)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory model: source image is bench-owned, reads return next cycle.
    logic [7:0] src_img [NPIX];
    logic [7:0] rdata    = 8'h00;
    logic       bad_addr = 1'b0;

    always @(posedge clk) begin
        if (bus.cs && !bus.we) begin
            rdata <= (bus.addr < 8'(NPIX)) ? src_img[bus.addr[3:0]] : 8'h00;
        end
        if ((bus.cs && !bus.we && bus.addr >= 8'(NPIX)) ||
            (bus.cs && bus.we && (bus.addr < 8'(DST) || bus.addr >= 8'(DST + NPIX)))) begin
            bad_addr <= 1'b1;
        end
    end

    assign bus.dout = rdata;

    int    checks = 0;
    int    errors = 0;
    coef_t cm [NTAP];
    exp_t  sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return int'(src_img[r*W + c]);
    endfunction

    function automatic int model(input int r, input int c, input int sh);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                s += int'(cm[(dy+1)*3 + (dx+1)]) * pix(r + dy, c + dx);
            end
        end
        if (sh > 0) s = (s + (1 << (sh - 1))) >>> sh;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) src_img[i] = 8'(i);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) src_img[i] = v;
    endtask

    task automatic model_identity();
        for (int i = 0; i < NTAP; i++) cm[i] = (i == 4) ? coef_t'(1) : coef_t'(0);
    endtask

    // Drives one idle-time coefficient write; indices above 8 must be
    // ignored, so the model only follows in-range writes.
    task automatic set_coef(input logic [3:0] idx, input logic [7:0] val);
        @(negedge clk);
        bus.h_write = 1'b1;
        bus.h_idx   = idx;
        bus.h_data  = val;
        @(negedge clk);
        bus.h_write = 1'b0;
        if (idx < 4'(NTAP)) cm[idx] = coef_t'(val);
    endtask

    // hw_at: -1 none, 0 together with start, n>0 during frame cycle n.
    task automatic run_frame(input string tag, input int sh, input int hw_at,
                             input logic [3:0] hw_idx, input logic [7:0] hw_val);
        int   n;
        bit   done;
        exp_t e;
        if (hw_at == 0 && hw_idx < 4'(NTAP)) cm[hw_idx] = coef_t'(hw_val);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                e.addr = 8'(DST + r*W + c);
                e.data = 8'(model(r, c, sh));
                sb.push_back(e);
            end
        end
        @(negedge clk);
        bus.start     = 1'b1;
        bus.cfg_shift = 4'(sh);
        if (hw_at == 0) begin
            bus.h_write = 1'b1;
            bus.h_idx   = hw_idx;
            bus.h_data  = hw_val;
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.h_write   = 1'b0;
        bus.cfg_shift = 4'd0;
        n    = 1;
        done = 1'b0;
        while (!done && n <= 200) begin
            if (n == 1) check({tag, ".busy"}, 32'(bus.busy), 32'd1);
            if (hw_at > 0 && n == hw_at) begin
                bus.h_write = 1'b1;
                bus.h_idx   = hw_idx;
                bus.h_data  = hw_val;
            end
            if (hw_at > 0 && n == hw_at + 1) bus.h_write = 1'b0;
            if (bus.cs && bus.we) begin
                if (sb.size() == 0) begin
                    check({tag, ".extra_wr"}, 32'(bus.addr), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("%s.addr%0d", tag, e.addr), 32'(bus.addr), 32'(e.addr));
                    check($sformatf("%s.data%0d", tag, e.addr), 32'(bus.din), 32'(e.data));
                end
            end
            if (bus.finish) begin
                done = 1'b1;
                check({tag, ".cycles"}, 32'(n), 32'(FRAME_CYC));
            end else begin
                @(negedge clk);
                n++;
            end
        end
        check({tag, ".finished"}, 32'(done), 32'd1);
        check({tag, ".missing_wr"}, 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        check({tag, ".idle"}, 32'(bus.busy), 32'd0);
        check({tag, ".addr_range"}, 32'(bad_addr), 32'd0);
    endtask

    initial begin
        n_reset       = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_shift = 4'd0;
        bus.h_write   = 1'b0;
        bus.h_idx     = 4'd0;
        bus.h_data    = 8'd0;
        fill_ramp();
        model_identity();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.cs",     32'(bus.cs),     32'd0);
        check("rst.we",     32'(bus.we),     32'd0);
        check("rst.addr",   32'(bus.addr),   32'd0);
        check("rst.din",    32'(bus.din),    32'd0);
        check("rst.finish", 32'(bus.finish), 32'd0);
        check("rst.busy",   32'(bus.busy),   32'd0);
        n_reset = 1'b1;

        // Identity copy after reset; an out-of-range index write must not disturb it
        set_coef(4'd13, 8'd5);
        run_frame("ident", 0, -1, 4'd0, 8'd0);

        // Box filter: corners 40, edges 60, interior 90
        for (int i = 0; i < NTAP; i++) set_coef(4'(i), 8'd1);
        fill_const(8'd10);
        run_frame("box10", 0, -1, 4'd0, 8'd0);

        // Clamp high
        fill_const(8'd200);
        run_frame("sat_hi", 0, -1, 4'd0, 8'd0);

        // Clamp low
        for (int i = 0; i < NTAP; i++) set_coef(4'(i), (i == 4) ? 8'hFF : 8'd0);
        fill_ramp();
        run_frame("sat_lo", 0, -1, 4'd0, 8'd0);

        // Rounding: (15+4)>>3 = 2, (6+4)>>3 = 1
        set_coef(4'd4, 8'd3);
        fill_const(8'd5);
        run_frame("rnd5", 3, -1, 4'd0, 8'd0);
        fill_const(8'd2);
        run_frame("rnd2", 3, -1, 4'd0, 8'd0);

        // Coefficient write while busy is ignored, then succeeds when idle
        set_coef(4'd4, 8'd1);
        fill_ramp();
        run_frame("busy_hw", 0, 10, 4'd4, 8'd7);
        set_coef(4'd4, 8'd7);
        run_frame("after_busy", 0, -1, 4'd0, 8'd0);

        // Coefficient write together with start is used by that frame
        run_frame("start_hw", 0, 0, 4'd4, 8'd2);

        // Async reset mid-frame
        set_coef(4'd0, 8'd2);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("mid_rst.cs",     32'(bus.cs),     32'd0);
        check("mid_rst.we",     32'(bus.we),     32'd0);
        check("mid_rst.busy",   32'(bus.busy),   32'd0);
        check("mid_rst.finish", 32'(bus.finish), 32'd0);
        check("mid_rst.addr",   32'(bus.addr),   32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        model_identity();
        run_frame("post_rst", 0, -1, 4'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
